// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared types and helpers for the CPU writeback path
package cpu_pkg;

  typedef logic [4:0] reg_idx_t;

  typedef struct packed {
    reg_idx_t    rd;
    logic [31:0] data;
  } wb_entry_t;

  // Architectural register count including x0: 32 for the full file, 16 for the reduced one
  function automatic int NUM_REGS(input int more_registers);
    return (more_registers != 0) ? 32 : 16;
  endfunction

endpackage

// File: rtl/cpu_wb_fifo.sv
// rtl/cpu_wb_fifo.sv - load-result queue feeding the writeback arbiter
module cpu_wb_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push,
  input  wb_entry_t push_data,
  input  logic      pop,
  output wb_entry_t head,
  output logic      full,
  output logic      empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  wb_entry_t      mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [AW:0]    count;
  logic           push_ok;
  logic           pop_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Entry storage; contents are don't-care until the count says otherwise
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/cpu_wb_stage.sv
// rtl/cpu_wb_stage.sv - writeback arbiter: ALU priority, queued loads, load scoreboard
module cpu_wb_stage
  import cpu_pkg::*;
#(
  parameter int MORE_REGISTERS = 1,
  parameter int LQ_DEPTH       = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [4:0]  mem_rd,
  input  logic [31:0] mem_data,
  input  logic        issue_fire,
  input  logic        issue_long,
  input  logic [4:0]  issue_rd,
  output logic [31:0] busy,
  output logic        wr,
  output logic [4:0]  addr_wr,
  output logic [31:0] data_wr
);

  localparam logic [5:0] NREGS = 6'(NUM_REGS(MORE_REGISTERS));

  wb_entry_t   q_head;
  wb_entry_t   push_entry;
  wb_entry_t   sel_entry;
  logic        q_full;
  logic        q_empty;
  logic        push;
  logic        pop;
  logic        sel_valid;
  logic        writable;
  logic [31:0] set_vec;
  logic [31:0] clr_vec;

  // mem_ready follows the registered count, so a same-cycle pop never opens a full queue
  assign mem_ready  = rst_n && !q_full;
  assign push       = mem_valid && mem_ready;
  assign push_entry = '{rd: mem_rd, data: mem_data};

  cpu_wb_fifo #(.DEPTH(LQ_DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (q_head),
    .full      (q_full),
    .empty     (q_empty)
  );

  // Source select: ALU always wins; the queue head drains only in ALU-free cycles
  always_comb begin
    sel_valid = 1'b0;
    sel_entry = '0;
    pop       = 1'b0;
    if (alu_valid) begin
      sel_valid = 1'b1;
      sel_entry = '{rd: alu_rd, data: alu_data};
    end else if (!q_empty) begin
      sel_valid = 1'b1;
      sel_entry = q_head;
      pop       = 1'b1;
    end
  end

  // x0 and registers outside the implemented file are consumed silently
  assign writable = sel_valid && (sel_entry.rd != '0) && ({1'b0, sel_entry.rd} < NREGS);

  // Registered write port; address and data only move when a write is issued
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr      <= 1'b0;
      addr_wr <= '0;
      data_wr <= '0;
    end else if (writable) begin
      wr      <= 1'b1;
      addr_wr <= sel_entry.rd;
      data_wr <= sel_entry.data;
    end else begin
      wr      <= 1'b0;
    end
  end

  assign set_vec = (issue_fire && issue_long && (issue_rd != '0)) ? (32'd1 << issue_rd) : '0;
  assign clr_vec = pop ? (32'd1 << q_head.rd) : '0;

  // Scoreboard: a popped load clears its bit, a new load issue sets it, set wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy <= '0;
    else        busy <= ((busy & ~clr_vec) | set_vec) & ~32'd1;
  end

endmodule

// File: tb/tb_cpu_wb_stage.sv
// tb/tb_cpu_wb_stage.sv - self-checking bench for cpu_wb_stage
module tb_cpu_wb_stage;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        alu_valid, mem_valid, issue_fire, issue_long;
  logic [4:0]  alu_rd, mem_rd, issue_rd;
  logic [31:0] alu_data, mem_data;

  logic        mem_ready1, wr1, mem_ready0, wr0;
  logic [31:0] busy1, data1, busy0, data0;
  logic [4:0]  addr1, addr0;

  cpu_wb_stage #(.MORE_REGISTERS(1), .LQ_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready1), .mem_rd(mem_rd), .mem_data(mem_data),
    .issue_fire(issue_fire), .issue_long(issue_long), .issue_rd(issue_rd),
    .busy(busy1), .wr(wr1), .addr_wr(addr1), .data_wr(data1)
  );

  cpu_wb_stage #(.MORE_REGISTERS(0), .LQ_DEPTH(2)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready0), .mem_rd(mem_rd), .mem_data(mem_data),
    .issue_fire(issue_fire), .issue_long(issue_long), .issue_rd(issue_rd),
    .busy(busy0), .wr(wr0), .addr_wr(addr0), .data_wr(data0)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  wb_entry_t q1[$];
  wb_entry_t q0[$];
  wb_entry_t e1, e0;

  typedef struct {
    logic        v;
    logic [4:0]  rd;
    logic [31:0] d;
    logic        e_wr;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    logic        e_wr0;
  } alu_vec_t;

  alu_vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected write for a given destination in each register-file size
  task automatic exp_wr(input logic [4:0] rd, input logic [31:0] d);
    if (rd != 5'd0) q1.push_back('{rd: rd, data: d});
    if (rd != 5'd0 && rd < 5'd16) q0.push_back('{rd: rd, data: d});
  endtask

  task automatic sb_empty(input string name);
    check({name, "_pending1"}, q1.size(), 0);
    check({name, "_pending0"}, q0.size(), 0);
    q1.delete();
    q0.delete();
  endtask

  // Scoreboard monitors: every write pops and matches the next expected entry
  always @(negedge clk) begin
    if (rst_n && wr1 === 1'b1) begin
      tests++;
      if (q1.size() == 0) begin
        fails++;
        $display("FAIL wr_unexpected1: got addr %0d data %h required no write", addr1, data1);
      end else begin
        e1 = q1.pop_front();
        if (addr1 !== e1.rd || data1 !== e1.data) begin
          fails++;
          $display("FAIL wr_match1: got %0d/%h required %0d/%h", addr1, data1, e1.rd, e1.data);
        end
      end
    end
    if (rst_n && wr0 === 1'b1) begin
      tests++;
      if (q0.size() == 0) begin
        fails++;
        $display("FAIL wr_unexpected0: got addr %0d data %h required no write", addr0, data0);
      end else begin
        e0 = q0.pop_front();
        if (addr0 !== e0.rd || data0 !== e0.data) begin
          fails++;
          $display("FAIL wr_match0: got %0d/%h required %0d/%h", addr0, data0, e0.rd, e0.data);
        end
      end
    end
  end

  initial begin
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    mem_valid = 0; mem_rd = 0; mem_data = 0;
    issue_fire = 0; issue_long = 0; issue_rd = 0;

    vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b1, 5'd5,  32'hDEADBEEF, 1'b1};
    vecs[1] = '{1'b0, 5'd9,  32'h00000000, 1'b0, 5'd5,  32'hDEADBEEF, 1'b0};
    vecs[2] = '{1'b1, 5'd31, 32'hFFFFFFFF, 1'b1, 5'd31, 32'hFFFFFFFF, 1'b0};
    vecs[3] = '{1'b1, 5'd0,  32'h12345678, 1'b0, 5'd31, 32'hFFFFFFFF, 1'b0};
    vecs[4] = '{1'b1, 5'd15, 32'h00000001, 1'b1, 5'd15, 32'h00000001, 1'b1};
    vecs[5] = '{1'b1, 5'd16, 32'hA5A5A5A5, 1'b1, 5'd16, 32'hA5A5A5A5, 1'b0};
    vecs[6] = '{1'b0, 5'd2,  32'h0BADF00D, 1'b0, 5'd16, 32'hA5A5A5A5, 1'b0};
    vecs[7] = '{1'b1, 5'd1,  32'hCAFEF00D, 1'b1, 5'd1,  32'hCAFEF00D, 1'b1};

    // Reset state
    #12;
    check("rst_wr", wr1, 0);
    check("rst_addr", addr1, 0);
    check("rst_data", data1, 0);
    check("rst_busy", busy1, 0);
    check("rst_ready", mem_ready1, 0);
    rst_n = 1'b1;
    #1;
    check("ready_after_rst", mem_ready1, 1);
    tick();

    // ALU-only vectors
    for (int i = 0; i < 8; i++) begin
      alu_valid = vecs[i].v;
      alu_rd    = vecs[i].rd;
      alu_data  = vecs[i].d;
      if (vecs[i].e_wr)  q1.push_back('{rd: vecs[i].rd, data: vecs[i].d});
      if (vecs[i].e_wr0) q0.push_back('{rd: vecs[i].rd, data: vecs[i].d});
      tick();
      check($sformatf("vec%0d_wr", i), wr1, vecs[i].e_wr);
      check($sformatf("vec%0d_addr", i), addr1, vecs[i].e_addr);
      check($sformatf("vec%0d_data", i), data1, vecs[i].e_data);
    end
    alu_valid = 0;
    tick();
    check("alu_idle_wr", wr1, 0);
    sb_empty("alu");

    // Single load to x7 tracked by the scoreboard
    issue_fire = 1; issue_long = 1; issue_rd = 7;
    tick();
    issue_fire = 0;
    check("ld7_busy_set", busy1, 32'h80);
    mem_valid = 1; mem_rd = 7; mem_data = 32'h1234;
    check("ld7_ready", mem_ready1, 1);
    exp_wr(7, 32'h1234);
    tick();
    mem_valid = 0;
    check("ld7_no_bypass", wr1, 0);
    check("ld7_busy_held", busy1, 32'h80);
    tick();
    check("ld7_wr", wr1, 1);
    check("ld7_addr", addr1, 7);
    check("ld7_busy_clr", busy1, 0);
    tick();
    sb_empty("ld7");

    // Two loads stalled by three ALU results, then a third beat blocked while full
    exp_wr(1, 32'h11); exp_wr(2, 32'h22); exp_wr(3, 32'h33);
    exp_wr(9, 32'hA1); exp_wr(10, 32'hB2); exp_wr(11, 32'hC3);
    alu_valid = 1; alu_rd = 1; alu_data = 32'h11;
    mem_valid = 1; mem_rd = 9; mem_data = 32'hA1;
    tick();
    alu_rd = 2; alu_data = 32'h22;
    mem_rd = 10; mem_data = 32'hB2;
    check("arb_ready_before_2nd", mem_ready1, 1);
    tick();
    check("arb_full_ready", mem_ready1, 0);
    alu_rd = 3; alu_data = 32'h33;
    mem_rd = 11; mem_data = 32'hC3;
    tick();
    check("arb_still_full", mem_ready1, 0);
    alu_valid = 0;
    tick();
    check("arb_first_pop_addr", addr1, 9);
    check("arb_ready_after_pop", mem_ready1, 1);
    tick();
    mem_valid = 0;
    check("arb_pushpop_ready", mem_ready1, 1);
    tick();
    tick();
    check("arb_busy_untouched", busy1, 0);
    sb_empty("arb");

    // Reduced register file drops x20; x0 is never written
    mem_valid = 1; mem_rd = 20; mem_data = 32'h20202020;
    exp_wr(20, 32'h20202020);
    tick();
    mem_valid = 0;
    tick();
    check("rd20_wr_full", wr1, 1);
    check("rd20_wr_reduced", wr0, 0);
    alu_valid = 1; alu_rd = 0; alu_data = 32'h55555555;
    tick();
    alu_valid = 0;
    check("x0_wr_full", wr1, 0);
    check("x0_wr_reduced", wr0, 0);
    tick();
    sb_empty("drop");

    // Re-issue to x3 on the edge the old x3 load retires
    issue_fire = 1; issue_long = 1; issue_rd = 3;
    tick();
    issue_fire = 0;
    check("x3_busy_set", busy1, 32'h08);
    mem_valid = 1; mem_rd = 3; mem_data = 32'h33;
    exp_wr(3, 32'h33);
    tick();
    mem_valid = 0;
    issue_fire = 1; issue_long = 1; issue_rd = 3;
    tick();
    issue_fire = 0;
    check("x3_set_wins", busy1, 32'h08);
    check("x3_set_wins0", busy0, 32'h08);
    tick();
    sb_empty("x3");

    // Reset with two queued loads and pending busy bits
    issue_fire = 1; issue_long = 1; issue_rd = 7;
    tick();
    issue_fire = 0;
    check("rst_seq_busy", busy1, 32'h88);
    alu_valid = 1; alu_rd = 2; alu_data = 32'h22;
    mem_valid = 1; mem_rd = 3; mem_data = 32'h3333;
    exp_wr(2, 32'h22);
    tick();
    alu_data = 32'h23;
    mem_rd = 7; mem_data = 32'h7777;
    exp_wr(2, 32'h23);
    tick();
    alu_valid = 0; mem_valid = 0;
    check("rst_seq_full", mem_ready1, 0);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_mid_busy", busy1, 0);
    check("rst_mid_ready", mem_ready1, 0);
    check("rst_mid_ready0", mem_ready0, 0);
    check("rst_mid_wr", wr1, 0);
    tick();
    check("rst_edge_busy", busy1, 0);
    check("rst_edge_ready", mem_ready1, 0);
    rst_n = 1'b1;
    #1;
    check("rst_release_ready", mem_ready1, 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("rst_after_wr%0d", i), wr1, 0);
    end
    sb_empty("rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cpu_wb_stage.md
CPU_WB_STAGE -- requirements
Module: cpu_wb_stage

Interface
REQ-001 SHALL have parameter MORE_REGISTERS, default 1; 1 = 31 writable registers (x1..x31), 0 = 15 (x1..x15).
REQ-002 SHALL have parameter LQ_DEPTH, default 2; load-result queue depth, power of two, at least 2.
REQ-003 SHALL have one clock and one reset; reset is asynchronous and active-low.
REQ-004 SHALL have port clk  in  1  clock.
REQ-005 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have port alu_valid  in  1  single-cycle result present this cycle; no backpressure.
REQ-007 SHALL have port alu_rd  in  5  ALU destination register.
REQ-008 SHALL have port alu_data  in  32  ALU result.
REQ-009 SHALL have port mem_valid  in  1  load result offered.
REQ-010 SHALL have port mem_ready  out  1  load queue accepts.
REQ-011 SHALL have port mem_rd  in  5  load destination register.
REQ-012 SHALL have port mem_data  in  32  load data.
REQ-013 SHALL have port issue_fire  in  1  instruction issued this cycle.
REQ-014 SHALL have port issue_long  in  1  issued instruction is a load.
REQ-015 SHALL have port issue_rd  in  5  destination of the issued instruction.
REQ-016 SHALL have port busy  out  32  scoreboard; bit i = load pending to xi; bit 0 always 0.
REQ-017 SHALL have port wr  out  1  register-file write enable.
REQ-018 SHALL have port addr_wr  out  5  register-file write address.
REQ-019 SHALL have port data_wr  out  32  register-file write data.

Function
REQ-020 SHALL accept a load beat when mem_valid and mem_ready are both high at a rising edge, pushing {mem_rd, mem_data} into the FIFO queue.
REQ-021 SHALL drive mem_ready = rst_n AND (queue count < LQ_DEPTH); a pop in the same cycle does not raise mem_ready when the queue is full.
REQ-022 SHALL select, each cycle, the ALU result if alu_valid is high; otherwise the queue head if the queue is non-empty; otherwise nothing.
REQ-023 SHALL pop the queue head only when it is selected; an ALU result stalls the queue for that cycle.
REQ-024 SHALL register the selection as a write-port update: wr, addr_wr and data_wr update at the edge where the source is sampled, so the register file writes at the following edge.
REQ-025 SHALL drive wr = 0 when nothing is selected; addr_wr and data_wr then hold their previous values.
REQ-026 SHALL consume, but not write, any selected entry whose rd is 0, or whose rd > 15 when MORE_REGISTERS = 0 (wr = 0).
REQ-027 SHALL set busy[issue_rd] at the edge where issue_fire, issue_long and issue_rd != 0 are all high.
REQ-028 SHALL clear busy[rd] at the edge where a queue entry with that rd is popped.
REQ-029 SHALL keep the bit set if a set and a clear of the same bit occur at the same edge (set wins).
REQ-030 SHALL leave busy unchanged on ALU writes; WAW hazard avoidance is the issue stage's job, using busy.
REQ-031 SHALL allow a push and a pop in the same cycle; the count is then unchanged, and pointers wrap modulo LQ_DEPTH.
REQ-032 SHALL NOT bypass an empty queue: a load accepted at edge N is selected no earlier than the cycle after N.

Reset
REQ-033 SHALL, while rst_n is low: wr = 0, addr_wr = 0, data_wr = 0, queue empty with pointers at 0, busy = 0, mem_ready = 0.
REQ-034 SHALL discard all queued entries and pending busy bits on reset assertion mid-operation; no write is issued for them afterwards.

Structure
REQ-035 SHALL take from the shared package cpu_pkg: the reg_idx_t (5-bit) type, the wb_entry_t struct {rd, data} and the NUM_REGS(MORE_REGISTERS) constant function.
REQ-036 SHALL implement the queue as a single sub-module cpu_wb_fifo (parameter DEPTH; push/pop/full/empty/head ports; asynchronous active-low reset); arbitration and the scoreboard stay in cpu_wb_stage.

Verification
REQ-037 SHALL cover, with MORE_REGISTERS = 1: alu_valid, rd = 5, data 0xDEADBEEF at edge 1 -> wr = 1, addr_wr = 5, data_wr = 0xDEADBEEF after edge 1 and wr = 0 after edge 2.
REQ-038 SHALL cover: issue load to x7, then mem beat (7, 0x1234) with no ALU traffic -> busy[7] = 1 until the write; wr with addr_wr = 7 one cycle after acceptance; busy[7] = 0 at that same edge.
REQ-039 SHALL cover: 2 load beats plus alu_valid held for 3 cycles -> mem_ready = 0 after the 2nd push; ALU writes occur first; loads write in FIFO order; mem_ready returns to 1 after the first pop.
REQ-040 SHALL cover: MORE_REGISTERS = 0, mem beat with rd = 20 -> entry popped, wr stays 0; ALU with rd = 0 -> wr stays 0.
REQ-041 SHALL cover: issue of a new load to x3 at the same edge the old x3 load pops -> busy[3] remains 1.
REQ-042 SHALL cover: rst_n low for 1 cycle with 2 entries queued and busy = 0x88 -> no further writes, busy = 0 and mem_ready = 0 during reset, mem_ready = 1 after release.
